// File: rtl/line_drawer_stream.sv
// Bresenham line rasteriser: accepts an endpoint pair on start and streams every
// pixel from (x0,y0) to (x1,y1) over a valid/ready handshake, all eight octants.
module line_drawer_stream #(
    parameter int XW = 10,
    parameter int YW = 9
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [XW-1:0] x0,
    input  logic [YW-1:0] y0,
    input  logic [XW-1:0] x1,
    input  logic [YW-1:0] y1,
    output logic          busy,
    output logic          pix_valid,
    input  logic          pix_ready,
    output logic [XW-1:0] pix_x,
    output logic [YW-1:0] pix_y,
    output logic          pix_last,
    output logic          done
);

    localparam int MW = (XW > YW) ? XW : YW;
    localparam int SW = MW + 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_DRAW  = 2'd2,
        ST_FIN   = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [XW-1:0]   cur_x_q, cur_x_d;
    logic [YW-1:0]   cur_y_q, cur_y_d;
    logic [XW-1:0]   end_x_q, end_x_d;
    logic [YW-1:0]   end_y_q, end_y_d;
    logic            steep_q, steep_d;
    logic            sx_q, sx_d;
    logic            sy_q, sy_d;
    logic [SW-1:0]   dmaj_q, dmaj_d;
    logic [SW-1:0]   dmin_q, dmin_d;
    logic [SW-1:0]   err_q, err_d;
    logic [MW-1:0]   rem_q, rem_d;
    logic            busy_q, busy_d;
    logic            pix_valid_q, pix_valid_d;
    logic            pix_last_q, pix_last_d;
    logic            done_q, done_d;

    logic [SW-1:0]   xs_s, xe_s, ys_s, ye_s;
    logic [SW-1:0]   dx_s, dy_s, dmaj_s, dmin_s;
    logic            steep_s;
    logic [SW-1:0]   e_s;
    logic            minor_step_s;
    logic [XW-1:0]   x_inc_s;
    logic [YW-1:0]   y_inc_s;
    logic [MW-1:0]   one_m_s;

    // Setup deltas and per-step Bresenham terms derived from the current registers.
    always_comb begin
        xs_s    = {{(SW-XW){1'b0}}, cur_x_q};
        xe_s    = {{(SW-XW){1'b0}}, end_x_q};
        ys_s    = {{(SW-YW){1'b0}}, cur_y_q};
        ye_s    = {{(SW-YW){1'b0}}, end_y_q};
        dx_s    = (xe_s >= xs_s) ? (xe_s - xs_s) : (xs_s - xe_s);
        dy_s    = (ye_s >= ys_s) ? (ye_s - ys_s) : (ys_s - ye_s);
        steep_s = (dy_s > dx_s);
        dmaj_s  = steep_s ? dy_s : dx_s;
        dmin_s  = steep_s ? dx_s : dy_s;
        // A negative trial error (sign bit set) means the minor axis advances.
        e_s          = err_q - dmin_q;
        minor_step_s = e_s[SW-1];
        x_inc_s      = sx_q ? {{(XW-1){1'b0}}, 1'b1} : {XW{1'b1}};
        y_inc_s      = sy_q ? {{(YW-1){1'b0}}, 1'b1} : {YW{1'b1}};
        one_m_s      = {{(MW-1){1'b0}}, 1'b1};
    end

    // Next-state and next-output computation for the IDLE/SETUP/DRAW/FIN sequence.
    always_comb begin
        state_d     = state_q;
        cur_x_d     = cur_x_q;
        cur_y_d     = cur_y_q;
        end_x_d     = end_x_q;
        end_y_d     = end_y_q;
        steep_d     = steep_q;
        sx_d        = sx_q;
        sy_d        = sy_q;
        dmaj_d      = dmaj_q;
        dmin_d      = dmin_q;
        err_d       = err_q;
        rem_d       = rem_q;
        pix_valid_d = pix_valid_q;
        pix_last_d  = pix_last_q;
        done_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    cur_x_d = x0;
                    cur_y_d = y0;
                    end_x_d = x1;
                    end_y_d = y1;
                    state_d = ST_SETUP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETUP: begin
                steep_d     = steep_s;
                sx_d        = (xe_s >= xs_s);
                sy_d        = (ye_s >= ys_s);
                dmaj_d      = dmaj_s;
                dmin_d      = dmin_s;
                err_d       = dmaj_s >> 1;
                rem_d       = dmaj_s[MW-1:0];
                pix_valid_d = 1'b1;
                pix_last_d  = (dmaj_s == {SW{1'b0}});
                state_d     = ST_DRAW;
            end
            ST_DRAW: begin
                if (pix_ready) begin
                    if (rem_q == {MW{1'b0}}) begin
                        pix_valid_d = 1'b0;
                        pix_last_d  = 1'b0;
                        done_d      = 1'b1;
                        state_d     = ST_FIN;
                    end else begin
                        if (steep_q) begin
                            cur_y_d = cur_y_q + y_inc_s;
                            if (minor_step_s) begin
                                cur_x_d = cur_x_q + x_inc_s;
                            end else begin
                                cur_x_d = cur_x_q;
                            end
                        end else begin
                            cur_x_d = cur_x_q + x_inc_s;
                            if (minor_step_s) begin
                                cur_y_d = cur_y_q + y_inc_s;
                            end else begin
                                cur_y_d = cur_y_q;
                            end
                        end
                        err_d      = minor_step_s ? (e_s + dmaj_q) : e_s;
                        rem_d      = rem_q - one_m_s;
                        pix_last_d = (rem_q == one_m_s);
                        state_d    = ST_DRAW;
                    end
                end else begin
                    state_d = ST_DRAW;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_SETUP) || (state_d == ST_DRAW);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cur_x_q     <= {XW{1'b0}};
            cur_y_q     <= {YW{1'b0}};
            end_x_q     <= {XW{1'b0}};
            end_y_q     <= {YW{1'b0}};
            steep_q     <= 1'b0;
            sx_q        <= 1'b0;
            sy_q        <= 1'b0;
            dmaj_q      <= {SW{1'b0}};
            dmin_q      <= {SW{1'b0}};
            err_q       <= {SW{1'b0}};
            rem_q       <= {MW{1'b0}};
            busy_q      <= 1'b0;
            pix_valid_q <= 1'b0;
            pix_last_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_x_q     <= cur_x_d;
            cur_y_q     <= cur_y_d;
            end_x_q     <= end_x_d;
            end_y_q     <= end_y_d;
            steep_q     <= steep_d;
            sx_q        <= sx_d;
            sy_q        <= sy_d;
            dmaj_q      <= dmaj_d;
            dmin_q      <= dmin_d;
            err_q       <= err_d;
            rem_q       <= rem_d;
            busy_q      <= busy_d;
            pix_valid_q <= pix_valid_d;
            pix_last_q  <= pix_last_d;
            done_q      <= done_d;
        end
    end

    assign busy      = busy_q;
    assign pix_valid = pix_valid_q;
    assign pix_x     = cur_x_q;
    assign pix_y     = cur_y_q;
    assign pix_last  = pix_last_q;
    assign done      = done_q;

endmodule

// File: tb/tb_line_drawer_stream.sv
// Scoreboard bench for line_drawer_stream: a closed-form rasterisation model fills the
// expected-pixel queue and a negedge monitor checks every accepted pixel.
module tb_line_drawer_stream;

    localparam int XW = 10;
    localparam int YW = 9;

    typedef struct packed {
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic          last;
    } pix_t;

    logic          clk = 1'b0;
    logic          reset, start, pix_ready;
    logic [XW-1:0] x0, x1, pix_x;
    logic [YW-1:0] y0, y1, pix_y;
    logic          busy, pix_valid, pix_last, done;

    pix_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   accepted_cnt = 0;
    bit   stall_en = 1'b0;
    bit   ready_low = 1'b0;

    bit            prev_stall = 1'b0;
    logic [XW-1:0] prev_x;
    logic [YW-1:0] prev_y;
    logic          prev_last;

    line_drawer_stream #(.XW(XW), .YW(YW)) dut (
        .clk(clk), .reset(reset), .start(start),
        .x0(x0), .y0(y0), .x1(x1), .y1(y1),
        .busy(busy), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_x(pix_x), .pix_y(pix_y), .pix_last(pix_last), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Pixel i along the major axis; the minor axis has advanced by the smallest k that
    // keeps floor(dmaj/2) - i*dmin + k*dmaj non-negative.
    task automatic model_push(input int ax0, input int ay0, input int ax1, input int ay1);
        int dx, dy, dmaj, dmin, h, k, sxi, syi, px, py;
        bit steep;
        pix_t p;
        dx = iabs(ax1 - ax0);
        dy = iabs(ay1 - ay0);
        steep = (dy > dx);
        dmaj = steep ? dy : dx;
        dmin = steep ? dx : dy;
        h = dmaj / 2;
        sxi = (ax1 >= ax0) ? 1 : -1;
        syi = (ay1 >= ay0) ? 1 : -1;
        for (int i = 0; i <= dmaj; i++) begin
            k = (i * dmin - h <= 0) ? 0 : (i * dmin - h + dmaj - 1) / dmaj;
            px = steep ? ax0 + sxi * k : ax0 + sxi * i;
            py = steep ? ay0 + syi * i : ay0 + syi * k;
            p.x = px[XW-1:0];
            p.y = py[YW-1:0];
            p.last = (i == dmaj);
            exp_q.push_back(p);
        end
    endtask

    // Consumer readiness: random when stalling, otherwise always ready.
    initial begin
        pix_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (ready_low) pix_ready = 1'b0;
            else if (stall_en) pix_ready = 1'($urandom_range(0, 1));
            else pix_ready = 1'b1;
        end
    end

    // Monitor: pops the scoreboard on each handshake and checks hold during stalls.
    always @(negedge clk) begin
        pix_t e;
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_hold", {pix_valid, pix_x, pix_y, pix_last},
                    {1'b1, prev_x, prev_y, prev_last});
            end
            if (pix_valid && pix_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_pixel", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("pix_x", pix_x, e.x);
                    chk("pix_y", pix_y, e.y);
                    chk("pix_last", pix_last, e.last);
                end
                accepted_cnt++;
            end
            prev_stall = pix_valid && !pix_ready;
            prev_x = pix_x;
            prev_y = pix_y;
            prev_last = pix_last;
        end
    end

    task automatic run_line(input int ax0, input int ay0, input int ax1, input int ay1,
                            input bit stall, input bit mid_start, input bit fin_start);
        int dmaj, first_c, done_c;
        bit busy_ok, busy_at_done;
        dmaj = (iabs(ax1 - ax0) > iabs(ay1 - ay0)) ? iabs(ax1 - ax0) : iabs(ay1 - ay0);
        model_push(ax0, ay0, ax1, ay1);
        stall_en = stall;
        @(posedge clk);
        #1;
        start = 1'b1;
        x0 = XW'(ax0); y0 = YW'(ay0); x1 = XW'(ax1); y1 = YW'(ay1);
        first_c = -1;
        done_c = -1;
        busy_ok = 1'b1;
        busy_at_done = 1'b1;
        for (int c = 0; c < 4000 && done_c < 0; c++) begin
            @(negedge clk);
            if (pix_valid && first_c < 0) first_c = c;
            if (done) begin
                done_c = c;
                busy_at_done = busy;
            end else if (c >= 1 && !busy) begin
                busy_ok = 1'b0;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            x0 = XW'($urandom); y0 = YW'($urandom); x1 = XW'($urandom); y1 = YW'($urandom);
            if (mid_start && c == 4) begin
                start = 1'b1;
                x0 = 10'd3; y0 = 9'd3; x1 = 10'd7; y1 = 9'd8;
            end
            if (fin_start && c + 1 == dmaj + 3) start = 1'b1;
        end
        start = 1'b0;
        chk("done_seen", done_c >= 0, 1);
        if (!stall) begin
            chk("first_pixel_latency", first_c, 2);
            chk("done_latency", done_c, dmaj + 3);
        end
        chk("busy_while_drawing", busy_ok, 1);
        chk("busy_low_at_done", busy_at_done, 0);
        chk("queue_empty_at_done", exp_q.size(), 0);
        exp_q.delete();
        @(negedge clk);
        chk("done_single_pulse", done, 0);
        chk("idle_busy", busy, 0);
        chk("idle_valid", pix_valid, 0);
    endtask

    initial begin
        int rx0, ry0, rx1, ry1, base;
        reset = 1'b1; start = 1'b0;
        x0 = '0; y0 = '0; x1 = '0; y1 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", {busy, pix_valid, pix_last, done, pix_x, pix_y}, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        run_line(0, 0, 10, 0, 1'b0, 1'b0, 1'b1);
        run_line(0, 0, 4, 9, 1'b0, 1'b0, 1'b0);
        run_line(4, 9, 0, 0, 1'b0, 1'b0, 1'b0);
        run_line(0, 4, 9, 0, 1'b0, 1'b0, 1'b0);
        run_line(9, 0, 0, 4, 1'b0, 1'b0, 1'b0);
        run_line(0, 0, 9, 4, 1'b0, 1'b0, 1'b0);
        run_line(9, 4, 0, 0, 1'b0, 1'b0, 1'b0);
        run_line(0, 0, 9, 4, 1'b1, 1'b0, 1'b0);
        run_line(5, 7, 5, 7, 1'b0, 1'b0, 1'b1);
        run_line(0, 0, 10, 0, 1'b0, 1'b1, 1'b0);
        run_line(0, 479, 639, 0, 1'b0, 1'b0, 1'b0);
        run_line(639, 0, 639, 479, 1'b1, 1'b0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            rx0 = $urandom_range(0, 639);
            ry0 = $urandom_range(0, 479);
            rx1 = rx0 + int'($urandom_range(0, 80)) - 40;
            ry1 = ry0 + int'($urandom_range(0, 80)) - 40;
            if (rx1 < 0) rx1 = 0;
            if (rx1 > 639) rx1 = 639;
            if (ry1 < 0) ry1 = 0;
            if (ry1 > 479) ry1 = 479;
            run_line(rx0, ry0, rx1, ry1, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        end

        // Reset after the third accepted pixel of a long line.
        model_push(0, 0, 639, 479);
        stall_en = 1'b0;
        base = accepted_cnt;
        @(posedge clk);
        #1;
        start = 1'b1;
        x0 = 10'd0; y0 = 9'd0; x1 = 10'd639; y1 = 9'd479;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int c = 0; c < 50 && accepted_cnt < base + 3; c++) @(posedge clk);
        chk("three_pixels_before_reset", accepted_cnt - base, 3);
        ready_low = 1'b1;
        #1;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("reset_midline_outputs", {busy, pix_valid, pix_last, done, pix_x, pix_y}, 0);
        exp_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        ready_low = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("no_done_after_reset", {done, busy, pix_valid}, 0);
        end
        run_line(100, 50, 90, 60, 1'b0, 1'b0, 1'b0);
        run_line(20, 30, 25, 10, 1'b1, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/line_drawer_stream.md
Name: line_drawer_stream

Overview:
Parametrised Bresenham line rasteriser for the VGA framebuffer path. Accepts a start/end coordinate pair on a start strobe, then streams every pixel of the line, all eight octants, in order from (x0,y0) to (x1,y1), over a valid/ready handshake so a slow framebuffer writer can stall it. Signals busy while drawing and pulses done when finished. Successor to the free-running line drawer: it adds a command handshake, backpressure, a last-pixel flag, endpoint-ordered output and configurable coordinate widths.

Parameters:
XW, 10, width of x coordinates in bits (640-wide screen).
YW, 9, width of y coordinates in bits (480-tall screen).

Ports:
clk  in  1  system clock; all logic on posedge.
reset  in  1  synchronous, active-high reset.
start  in  1  command strobe; sampled only in IDLE.
x0  in  XW  start x, unsigned.
y0  in  YW  start y, unsigned.
x1  in  XW  end x, unsigned.
y1  in  YW  end y, unsigned.
busy  out  1  high from the cycle after start is accepted until done is asserted.
pix_valid  out  1  pix_x/pix_y hold a valid pixel.
pix_ready  in  1  consumer accepts the pixel when pix_valid && pix_ready.
pix_x  out  XW  pixel x.
pix_y  out  YW  pixel y.
pix_last  out  1  qualifies pix_valid; high only on the final pixel.
done  out  1  one-cycle pulse after the final pixel is accepted.

Behaviour:
- Reset: state IDLE; busy, pix_valid, pix_last, done = 0; pix_x, pix_y = 0; internal error and counters = 0. Reset overrides everything, including a line in progress; no done pulse follows.
- States: IDLE -> SETUP -> DRAW -> FIN -> IDLE.
- IDLE: on start=1, latch x0,y0,x1,y1 and go to SETUP. start is ignored in every other state.
- SETUP (1 cycle, busy=1):
  - dx = |x1-x0|, dy = |y1-y0|.
  - steep = (dy > dx); ties are x-major.
  - Major axis = y if steep, else x. dmaj/dmin = the major/minor deltas. Major and minor step signs are +1 if end >= start, else -1.
  - err = dmaj >> 1; remaining = dmaj; cur = (x0,y0).
  - Signed arithmetic width: max(XW,YW)+2 bits. No overflow is permitted for any input.
- DRAW: pix_valid=1, pix_x/pix_y=cur, pix_last=(remaining==0).
  - While pix_valid && !pix_ready: every pixel output and all internal state hold unchanged.
  - On a handshake with remaining != 0: step major by its sign; e = err - dmin; if e < 0, step minor and err = e + dmaj, else err = e; remaining -= 1. The next pixel is presented the following cycle with no bubble.
  - On a handshake with remaining == 0: go to FIN and drop pix_valid.
- FIN (1 cycle): done=1, busy=0, then IDLE. A start in FIN is ignored. A start in the cycle after FIN is accepted.
- Latency: start accepted at edge N; first pix_valid visible after edge N+2. Throughput is one pixel per cycle when pix_ready=1. A line of dmaj+1 pixels with no stalls has done high dmaj+3 cycles after start is accepted.
- Degenerate point (x0==x1, y0==y1): exactly one pixel with pix_last=1.
- Pixel count is always max(dx,dy)+1. The first pixel is exactly (x0,y0) and the last is exactly (x1,y1).
- Coordinates never leave the bounding box of the two endpoints.

Test Plan:
- Horizontal (0,0)->(10,0), pix_ready=1 -> 11 pixels x=0..10, y=0; pix_last only on (10,0); done pulses once; first pixel two cycles after start.
- Steep (0,0)->(4,9) -> exactly (0,0),(0,1),(1,2),(1,3),(2,4),(2,5),(3,6),(3,7),(4,8),(4,9); pix_last on (4,9).
- Reverse steep (4,9)->(0,0) -> (4,9),(4,8),(3,7),(3,6),(2,5),(2,4),(1,3),(1,2),(0,1),(0,0). Also run the gradual lines (0,4)->(9,0) and (9,0)->(0,4) in all four quadrant directions -> 10 pixels each, correct endpoints, monotonic steps.
- Backpressure: (0,0)->(9,4) with pix_ready toggled randomly -> the accepted sequence equals the unstalled sequence; outputs stay stable during stalls; no pixel dropped or duplicated.
- Point (5,7)->(5,7) -> one pixel (5,7) with pix_last=1, then done; a start pulsed mid-line on (0,0)->(10,0) is ignored and the line completes unchanged.
- Reset asserted after the 3rd pixel of (0,0)->(639,479) -> next cycle: IDLE, all outputs 0, no done pulse; a new start then draws correctly from its own (x0,y0).
